btn_debounce: RTL and testbench

//   Debounces one raw board push-button using the divided sample clock from the clock divider.

---
 rtl/btn_debounce_pkg.sv | 25 ++
 rtl/btn_debounce_sync_2ff.sv | 36 +++
 rtl/btn_debounce.sv | 215 +++++++++++++++++++++
 tb/tb_btn_debounce.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/btn_debounce_pkg.sv
// -----------------------------------------------------------------------------
// btn_debounce_pkg
//   Shared definitions for the push-button debouncers: the four-state debounce
//   FSM encoding and the default number of stable samples. Every button
//   instance imports this package so the encoding stays identical across them.
// -----------------------------------------------------------------------------
package btn_debounce_pkg;

  // Debounce FSM states (2-bit encoding shared by all button instances)
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_e;

  // Consecutive identical samples needed before a new level is accepted
  localparam int DEFAULT_STABLE_CNT = 4;

  // Level the raw pin shows while the button is released
  function automatic logic inactive_level(input int active_low);
    return (active_low != 0) ? 1'b1 : 1'b0;
  endfunction

endpackage : btn_debounce_pkg

// File: rtl/btn_debounce_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchroniser for a single asynchronous bit, with a parameterised
//   value loaded by the synchronous active-low reset.
// Ports:
//   clk_in  in   destination clock
//   rst_n   in   synchronous reset, active low
//   d       in   asynchronous input bit
//   q       out  synchronised bit (two clk_in cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule : sync_2ff

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   Debounces one raw push-button. slow_clk (from the clock divider) is used as
//   data, not as a clock: every transition of it is one sample tick. A new
//   button state is accepted after STABLE_CNT consecutive identical samples.
//   Outputs a registered clean level and one-cycle press/release pulses.
//
//   Optional feature macro: BTN_REPEAT_EN
//     defined   : auto-repeat press pulses while held (REPEAT_DELAY ticks until
//                 the first repeat, then every REPEAT_PERIOD ticks)
//     undefined : no repeat logic; REPEAT_* parameters are only sanity-checked
//
// Ports:
//   clk_in       in   system clock
//   rst_n        in   synchronous reset, active low
//   slow_clk     in   divided clock; each edge is one sample tick
//   btn_raw      in   asynchronous raw button pin
//   btn_level    out  debounced state, 1 = pressed
//   btn_press    out  one-cycle pulse on accepted press (and on each repeat)
//   btn_release  out  one-cycle pulse on accepted release
// -----------------------------------------------------------------------------
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int STABLE_CNT    = DEFAULT_STABLE_CNT,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_DELAY  = 1000,
  parameter int REPEAT_PERIOD = 200,
  parameter int CNT_W         = 16
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic slow_clk,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam logic             INACTIVE   = inactive_level(ACTIVE_LOW);
  localparam logic [CNT_W-1:0] STABLE_LIM = CNT_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  // Elaboration-time parameter sanity checks
  if (STABLE_CNT < 2) begin : g_bad_stable
    $error("btn_debounce: STABLE_CNT must be at least 2");
  end
  if ((64'(STABLE_CNT) >> CNT_W) != 64'd0) begin : g_bad_width
    $error("btn_debounce: CNT_W too narrow for STABLE_CNT");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("btn_debounce: REPEAT_DELAY and REPEAT_PERIOD must be positive");
  end

  logic             w_btn_sync;
  logic             w_slow_sync;
  logic             w_tick;
  logic             w_pressed;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_rpt_fire;

  btn_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_slow_prev;
  logic             r_level;
  logic             r_press;
  logic             r_release;

  sync_2ff #(.RST_VAL(INACTIVE)) u_sync_btn (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .d      (btn_raw),
    .q      (w_btn_sync)
  );

  sync_2ff #(.RST_VAL(1'b0)) u_sync_slow (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .d      (slow_clk),
    .q      (w_slow_sync)
  );

  // Either edge of the synchronised slow clock is a sample tick
  assign w_tick    = w_slow_sync ^ r_slow_prev;
  assign w_pressed = w_btn_sync ^ INACTIVE;

  // Saturating increment of the stability counter
  always_comb begin
    w_cnt_inc = r_cnt;
    if (r_cnt != CNT_MAX) begin
      w_cnt_inc = r_cnt + CNT_W'(1);
    end else begin
      w_cnt_inc = CNT_MAX;
    end
  end

`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W:0] RPT_FIRST  = (CNT_W + 1)'(REPEAT_DELAY);
  localparam logic [CNT_W:0] RPT_RELOAD = (CNT_W + 1)'(REPEAT_DELAY + REPEAT_PERIOD);

  logic [CNT_W-1:0] r_rpt_cnt;
  logic [CNT_W-1:0] w_rpt_next;
  logic [CNT_W:0]   w_rpt_inc;

  // Repeat counter next value; after the first repeat it folds back to
  // REPEAT_DELAY every REPEAT_PERIOD ticks so it never has to wrap
  always_comb begin
    w_rpt_inc  = {1'b0, r_rpt_cnt} + (CNT_W + 1)'(1);
    w_rpt_next = r_rpt_cnt;
    w_rpt_fire = 1'b0;
    if (w_rpt_inc == RPT_FIRST) begin
      w_rpt_next = w_rpt_inc[CNT_W-1:0];
      w_rpt_fire = 1'b1;
    end else if (w_rpt_inc == RPT_RELOAD) begin
      w_rpt_next = RPT_FIRST[CNT_W-1:0];
      w_rpt_fire = 1'b1;
    end else if (r_rpt_cnt == CNT_MAX) begin
      w_rpt_next = CNT_MAX;
    end else begin
      w_rpt_next = w_rpt_inc[CNT_W-1:0];
    end
  end

  // Counts held ticks in PRESSED, holds through RELEASE_WAIT, clears in IDLE
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_rpt_cnt <= {CNT_W{1'b0}};
    end else if (r_state == ST_IDLE) begin
      r_rpt_cnt <= {CNT_W{1'b0}};
    end else if (w_tick && (r_state == ST_PRESSED) && w_pressed) begin
      r_rpt_cnt <= w_rpt_next;
    end else begin
      r_rpt_cnt <= r_rpt_cnt;
    end
  end
`else
  assign w_rpt_fire = 1'b0;
`endif

  // Debounce FSM with registered level and pulse outputs; advances on ticks only
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= {CNT_W{1'b0}};
      r_slow_prev <= 1'b0;
      r_level     <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
    end else begin
      r_slow_prev <= w_slow_sync;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      if (w_tick) begin
        case (r_state)
          ST_IDLE: begin
            if (w_pressed) begin
              r_state <= ST_PRESS_WAIT;
              r_cnt   <= CNT_W'(1);
            end else begin
              r_cnt   <= {CNT_W{1'b0}};
            end
          end
          ST_PRESS_WAIT: begin
            if (!w_pressed) begin
              r_state <= ST_IDLE;
              r_cnt   <= {CNT_W{1'b0}};
            end else if (w_cnt_inc == STABLE_LIM) begin
              r_state <= ST_PRESSED;
              r_cnt   <= {CNT_W{1'b0}};
              r_level <= 1'b1;
              r_press <= 1'b1;
            end else begin
              r_cnt   <= w_cnt_inc;
            end
          end
          ST_PRESSED: begin
            if (!w_pressed) begin
              r_state <= ST_RELEASE_WAIT;
              r_cnt   <= CNT_W'(1);
            end else begin
              r_press <= w_rpt_fire;
            end
          end
          ST_RELEASE_WAIT: begin
            if (w_pressed) begin
              // Bounce back to pressed: level never dropped, so no pulse
              r_state <= ST_PRESSED;
              r_cnt   <= {CNT_W{1'b0}};
            end else if (w_cnt_inc == STABLE_LIM) begin
              r_state   <= ST_IDLE;
              r_cnt     <= {CNT_W{1'b0}};
              r_level   <= 1'b0;
              r_release <= 1'b1;
            end else begin
              r_cnt     <= w_cnt_inc;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_level <= 1'b0;
          end
        endcase
      end else begin
        r_state <= r_state;
        r_cnt   <= r_cnt;
      end
    end
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;

endmodule : btn_debounce

// File: tb/tb_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce
//   Directed bench for btn_debounce with STABLE_CNT=4, ACTIVE_LOW=1 and
//   slow_clk toggled every 10 clk_in cycles. Each call of do_tick drives one
//   raw level for one sample tick and checks the pulses seen around that tick.
// -----------------------------------------------------------------------------
module tb_btn_debounce;

  logic clk_in   = 1'b0;
  logic rst_n    = 1'b0;
  logic slow_clk = 1'b0;
  logic btn_raw  = 1'b0;
  logic btn_level;
  logic btn_press;
  logic btn_release;

  int n_checks = 0;
  int n_pass   = 0;

  int press_cnt;
  int rel_cnt;
  int both_cnt;
  int press_off;
  int cyc;

  always #5 clk_in = ~clk_in;

  btn_debounce #(
    .STABLE_CNT    (4),
    .ACTIVE_LOW    (1),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (3),
    .CNT_W         (16)
  ) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .slow_clk    (slow_clk),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Sample outputs on the falling edge; cyc counts cycles since the toggle
  task automatic watch_cycle();
    @(negedge clk_in);
    cyc++;
    if (btn_press) begin
      press_cnt++;
      press_off = cyc;
    end
    if (btn_release) rel_cnt++;
    if (btn_press && btn_release) both_cnt++;
  endtask

  // One sample tick: drive raw, toggle slow_clk mid-window, check the window
  task automatic do_tick(input logic raw, input int exp_p, input int exp_r,
                         input int exp_lvl, input string tag);
    press_cnt = 0;
    rel_cnt   = 0;
    both_cnt  = 0;
    press_off = -100;
    cyc       = -5;
    btn_raw   = raw;
    repeat (5) watch_cycle();
    slow_clk = ~slow_clk;
    repeat (5) watch_cycle();
    chk({tag, ".press"},   press_cnt, exp_p);
    chk({tag, ".release"}, rel_cnt,   exp_r);
    chk({tag, ".level"},   int'(btn_level), exp_lvl);
    chk({tag, ".excl"},    both_cnt,  0);
  endtask

  initial begin
    int ep;

    // 1. Reset with button held, then one press after 4 ticks
    rst_n   = 1'b0;
    btn_raw = 1'b0;
    repeat (5) @(negedge clk_in);
    chk("t1.rst.level",   int'(btn_level),   0);
    chk("t1.rst.press",   int'(btn_press),   0);
    chk("t1.rst.release", int'(btn_release), 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) do_tick(1'b0, 0, 0, 0, $sformatf("t1.%0d", i));
    do_tick(1'b0, 1, 0, 1, "t1.4");
    chk("t1.latency", press_off, 3);

    // Release to reach IDLE
    for (int i = 1; i <= 3; i++) do_tick(1'b1, 0, 0, 1, $sformatf("r1.%0d", i));
    do_tick(1'b1, 0, 1, 0, "r1.4");

    // 2. Clean press held 6 ticks
    for (int i = 1; i <= 3; i++) do_tick(1'b0, 0, 0, 0, $sformatf("t2.%0d", i));
    do_tick(1'b0, 1, 0, 1, "t2.4");
    chk("t2.latency", press_off, 3);
    do_tick(1'b0, 0, 0, 1, "t2.5");
    do_tick(1'b0, 0, 0, 1, "t2.6");

    // Release to reach IDLE
    for (int i = 1; i <= 3; i++) do_tick(1'b1, 0, 0, 1, $sformatf("r2.%0d", i));
    do_tick(1'b1, 0, 1, 0, "r2.4");

    // 3. Bounce: low 2, high 1, low 4
    do_tick(1'b0, 0, 0, 0, "t3.l1");
    do_tick(1'b0, 0, 0, 0, "t3.l2");
    do_tick(1'b1, 0, 0, 0, "t3.h1");
    for (int i = 1; i <= 3; i++) do_tick(1'b0, 0, 0, 0, $sformatf("t3.f%0d", i));
    do_tick(1'b0, 1, 0, 1, "t3.f4");

    // 4. Release bounce: high 2, low 1, high 4
    do_tick(1'b1, 0, 0, 1, "t4.h1");
    do_tick(1'b1, 0, 0, 1, "t4.h2");
    do_tick(1'b0, 0, 0, 1, "t4.l1");
    for (int i = 1; i <= 3; i++) do_tick(1'b1, 0, 0, 1, $sformatf("t4.f%0d", i));
    do_tick(1'b1, 0, 1, 0, "t4.f4");

    // 5. Reset while PRESSED with the button held
    for (int i = 1; i <= 3; i++) do_tick(1'b0, 0, 0, 0, $sformatf("t5.p%0d", i));
    do_tick(1'b0, 1, 0, 1, "t5.p4");
    if (slow_clk) do_tick(1'b0, 0, 0, 1, "t5.align");
    rst_n = 1'b0;
    @(negedge clk_in);
    chk("t5.rst.level",   int'(btn_level),   0);
    chk("t5.rst.press",   int'(btn_press),   0);
    chk("t5.rst.release", int'(btn_release), 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) do_tick(1'b0, 0, 0, 0, $sformatf("t5.a%0d", i));
    do_tick(1'b0, 1, 0, 1, "t5.a4");

    // Release to reach IDLE
    for (int i = 1; i <= 3; i++) do_tick(1'b1, 0, 0, 1, $sformatf("r5.%0d", i));
    do_tick(1'b1, 0, 1, 0, "r5.4");

    // 6. Long hold: press at tick 4, repeats at 14, 17, 20 when enabled
    for (int i = 1; i <= 20; i++) begin
      ep = (i == 4) ? 1 : 0;
`ifdef BTN_REPEAT_EN
      if (i == 14 || i == 17 || i == 20) ep = 1;
`endif
      do_tick(1'b0, ep, 0, (i >= 4) ? 1 : 0, $sformatf("t6.%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_btn_debounce
